// File: rtl/mips_harvard_mem.sv
// Word-addressed memory responder for the Harvard MIPS CPU.
// Combinational-read instruction and data stores, a sequential boot loader
// for the instruction store, and a sticky monitor for illegal data accesses.
// Storage arrays are never reset, so a loaded program survives a reset.
module mips_harvard_mem #(
   parameter logic [31:0] INSTR_BASE  = 32'hBFC00000,
   parameter int          INSTR_WORDS = 256,
   parameter logic [31:0] DATA_BASE   = 32'h00000000,
   parameter int          DATA_WORDS  = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic [31:0] instr_address,
   output logic [31:0] instr_readdata,
   input  logic [31:0] data_address,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [31:0] data_writedata,
   output logic [31:0] data_readdata,
   input  logic        init_mem,
   input  logic [31:0] init_mem_addr,
   input  logic [31:0] init_instr,
   output logic        instr_active,
   output logic        fault,
   output logic [31:0] fault_addr
);

   localparam int IW = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
   localparam int DW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [31:0] instr_mem [INSTR_WORDS];
   logic [31:0] data_mem  [DATA_WORDS];

   // Window hit: at or above the base and the word offset inside the depth.
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int          words);
      return (addr >= base) && (((addr - base) >> 2) < 32'(words));
   endfunction

   function automatic logic [IW-1:0] instr_index(input logic [31:0] addr);
      return IW'((addr - INSTR_BASE) >> 2);
   endfunction

   function automatic logic [DW-1:0] data_index(input logic [31:0] addr);
      return DW'((addr - DATA_BASE) >> 2);
   endfunction

   logic init_hit;
   logic fetch_hit;
   logic d_aligned;
   logic d_in_data;
   logic d_in_instr;
   logic ready;
   logic access;
   logic fault_cond;
   logic store_commit;

   assign init_hit   = (init_mem_addr[1:0] == 2'b00) &&
                       in_window(init_mem_addr, INSTR_BASE, INSTR_WORDS);
   assign fetch_hit  = (instr_address[1:0] == 2'b00) &&
                       in_window(instr_address, INSTR_BASE, INSTR_WORDS);
   assign d_aligned  = (data_address[1:0] == 2'b00);
   assign d_in_data  = in_window(data_address, DATA_BASE, DATA_WORDS);
   assign d_in_instr = in_window(data_address, INSTR_BASE, INSTR_WORDS);
   assign ready      = (state == ST_READY);
   assign access     = data_read | data_write;

   // Illegal accesses only count while serving the CPU with the clock enabled.
   assign fault_cond = ready && clk_enable && access &&
                       ((data_read && data_write) ||
                        !d_aligned ||
                        (!d_in_data && !d_in_instr) ||
                        (data_write && d_in_instr));

   // A faulting store never reaches the array.
   assign store_commit = ready && clk_enable && data_write &&
                         d_in_data && d_aligned && !fault_cond;

   assign instr_active = ready;

   // Loader FSM state register; reset returns to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: any init strobe means loading; the first quiet cycle in LOAD hands over.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (init_mem) state_next = ST_LOAD;
         ST_LOAD:  if (!init_mem) state_next = ST_READY;
         ST_READY: if (init_mem) state_next = ST_LOAD;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Instruction store writes from the loader; independent of reset and state.
   always_ff @(posedge clk) begin
      if (init_mem && init_hit) begin
         instr_mem[instr_index(init_mem_addr)] <= init_instr;
      end
   end

   // Data store writes from committed CPU stores.
   always_ff @(posedge clk) begin
      if (store_commit) begin
         data_mem[data_index(data_address)] <= data_writedata;
      end
   end

   // Fetch port: aligned window hits read the store, everything else reads zero.
   always_comb begin
      instr_readdata = 32'h0;
      if (fetch_hit) begin
         instr_readdata = instr_mem[instr_index(instr_address)];
      end
   end

   // Load port: data window first, then read-only view of the instruction window.
   always_comb begin
      data_readdata = 32'h0;
      if (ready && data_read && d_aligned) begin
         if (d_in_data) begin
            data_readdata = data_mem[data_index(data_address)];
         end else if (d_in_instr) begin
            data_readdata = instr_mem[instr_index(data_address)];
         end
      end
   end

   // Sticky fault flag and first-fault address; reset takes priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         fault      <= 1'b0;
         fault_addr <= 32'h0;
      end else if (fault_cond && !fault) begin
         fault      <= 1'b1;
         fault_addr <= data_address;
      end
   end

endmodule

// File: tb/tb_mips_harvard_mem.sv
// Self-checking bench for mips_harvard_mem: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model built from arrays and a couple of mode flags.
module tb_mips_harvard_mem;

   localparam logic [31:0] IB  = 32'hBFC00000;
   localparam int          IWN = 256;
   localparam logic [31:0] DB  = 32'h00000000;
   localparam int          DWN = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_enable = 1'b0;
   logic [31:0] instr_address = 32'h0;
   logic [31:0] instr_readdata;
   logic [31:0] data_address = 32'h0;
   logic        data_read = 1'b0;
   logic        data_write = 1'b0;
   logic [31:0] data_writedata = 32'h0;
   logic [31:0] data_readdata;
   logic        init_mem = 1'b0;
   logic [31:0] init_mem_addr = 32'h0;
   logic [31:0] init_instr = 32'h0;
   logic        instr_active;
   logic        fault;
   logic [31:0] fault_addr;

   always #5 clk = ~clk;

   mips_harvard_mem #(
      .INSTR_BASE (IB),
      .INSTR_WORDS(IWN),
      .DATA_BASE  (DB),
      .DATA_WORDS (DWN)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .clk_enable    (clk_enable),
      .instr_address (instr_address),
      .instr_readdata(instr_readdata),
      .data_address  (data_address),
      .data_read     (data_read),
      .data_write    (data_write),
      .data_writedata(data_writedata),
      .data_readdata (data_readdata),
      .init_mem      (init_mem),
      .init_mem_addr (init_mem_addr),
      .init_instr    (init_instr),
      .instr_active  (instr_active),
      .fault         (fault),
      .fault_addr    (fault_addr)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit [31:0] im [IWN];
   bit        ik [IWN];
   bit [31:0] dm [DWN];
   bit        dk [DWN];
   bit        m_serving = 0;
   bit        m_loading = 0;
   bit        m_fault = 0;
   bit [31:0] m_fa = 0;
   bit        m_valid = 0;

   // Byte address to word index using wide arithmetic so nothing wraps.
   function automatic bit win(input logic [31:0] a, input logic [31:0] base,
                              input int words, output int idx);
      longint la, lb;
      la = {32'b0, a};
      lb = {32'b0, base};
      idx = 0;
      if (la >= lb && (la - lb) / 4 < longint'(words)) begin
         idx = int'((la - lb) / 4);
         return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_step();
      int  ii, di, xi;
      bit  dh, ih, mis, fc;
      if (init_mem && init_mem_addr[1:0] == 2'b00 && win(init_mem_addr, IB, IWN, ii)) begin
         im[ii] = init_instr;
         ik[ii] = 1'b1;
      end
      dh  = win(data_address, DB, DWN, di);
      ih  = win(data_address, IB, IWN, xi);
      mis = (data_address[1:0] != 2'b00);
      fc  = m_serving && clk_enable && (data_read || data_write) &&
            ((data_read && data_write) || mis || (!dh && !ih) || (data_write && ih));
      if (m_serving && clk_enable && data_write && dh && !fc) begin
         dm[di] = data_writedata;
         dk[di] = 1'b1;
      end
      if (reset) begin
         m_fault = 1'b0;
         m_fa    = 32'h0;
      end else if (fc && !m_fault) begin
         m_fault = 1'b1;
         m_fa    = data_address;
      end
      if (reset) begin
         m_serving = 1'b0;
         m_loading = 1'b0;
         m_valid   = 1'b1;
      end else if (init_mem) begin
         m_loading = 1'b1;
         m_serving = 1'b0;
      end else if (m_loading) begin
         m_loading = 1'b0;
         m_serving = 1'b1;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Every-cycle comparison on the falling edge.
   task automatic compare_all();
      int  ii, di, xi;
      bit  ih, dh, dih;
      ih = (instr_address[1:0] == 2'b00) && win(instr_address, IB, IWN, ii);
      if (!ih) check("cyc_instr_miss", instr_readdata, 32'h0);
      else if (ik[ii]) check("cyc_instr", instr_readdata, im[ii]);
      if (!(m_serving && data_read) || data_address[1:0] != 2'b00) begin
         check("cyc_data_zero", data_readdata, 32'h0);
      end else begin
         dh  = win(data_address, DB, DWN, di);
         dih = win(data_address, IB, IWN, xi);
         if (dh) begin
            if (dk[di]) check("cyc_data", data_readdata, dm[di]);
         end else if (dih) begin
            if (ik[xi]) check("cyc_data_iwin", data_readdata, im[xi]);
         end else begin
            check("cyc_data_miss", data_readdata, 32'h0);
         end
      end
      check("cyc_active", {31'b0, instr_active}, {31'b0, m_serving});
      check("cyc_fault", {31'b0, fault}, {31'b0, m_fault});
      check("cyc_fault_addr", fault_addr, m_fa);
   endtask

   initial forever begin
      @(negedge clk);
      if (m_valid) compare_all();
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      data_read  = 1'b0;
      data_write = 1'b0;
      init_mem   = 1'b0;
   endtask

   int burst = 0;

   initial begin
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      data_read = 1'b1;
      data_address = 32'h10;
      #1;
      check("rst_active", {31'b0, instr_active}, 32'h0);
      check("rst_fault", {31'b0, fault}, 32'h0);
      check("rst_fault_addr", fault_addr, 32'h0);
      check("rst_data_zero", data_readdata, 32'h0);
      data_read = 1'b0;

      // Fill the whole instruction window; the first two words are the known program.
      for (int i = 0; i < IWN; i++) begin
         init_mem = 1'b1;
         init_mem_addr = IB + 32'(4 * i);
         init_instr = (i == 0) ? 32'h8C0C0000 : (i == 1) ? 32'h25830068 : $urandom;
         tick();
      end
      init_mem = 1'b0;
      #1;
      check("load_not_active", {31'b0, instr_active}, 32'h0);
      tick();
      instr_address = IB + 32'h4;
      #1;
      check("load_active", {31'b0, instr_active}, 32'h1);
      check("load_word1", instr_readdata, 32'h25830068);

      // Zero the data words exercised below.
      clk_enable = 1'b1;
      for (int i = 0; i < 64; i++) begin
         data_write = 1'b1;
         data_address = 32'(4 * i);
         data_writedata = 32'h0;
         tick();
      end
      data_write = 1'b0;

      // Store then load.
      data_read = 1'b1;
      data_address = 32'h10;
      #1;
      check("old_value", data_readdata, 32'h0);
      data_read = 1'b0;
      data_write = 1'b1;
      data_writedata = 32'd104;
      tick();
      data_write = 1'b0;
      data_read = 1'b1;
      #1;
      check("store_load", data_readdata, 32'd104);

      // Gated store leaves memory alone.
      data_read = 1'b0;
      data_write = 1'b1;
      clk_enable = 1'b0;
      data_writedata = 32'd55;
      tick();
      data_write = 1'b0;
      clk_enable = 1'b1;
      data_read = 1'b1;
      #1;
      check("gated_store", data_readdata, 32'd104);
      check("gated_no_fault", {31'b0, fault}, 32'h0);

      // Misaligned store, then store into the instruction window.
      data_read = 1'b0;
      data_write = 1'b1;
      data_address = 32'h12;
      data_writedata = 32'd77;
      tick();
      #1;
      check("fault_set", {31'b0, fault}, 32'h1);
      check("fault_addr_first", fault_addr, 32'h12);
      data_address = IB;
      data_writedata = 32'hDEADBEEF;
      tick();
      data_write = 1'b0;
      #1;
      check("fault_sticky", {31'b0, fault}, 32'h1);
      check("fault_addr_kept", fault_addr, 32'h12);
      instr_address = IB;
      data_read = 1'b1;
      data_address = 32'h10;
      #1;
      check("iwin_not_written", instr_readdata, 32'h8C0C0000);
      check("misaligned_not_written", data_readdata, 32'd104);

      // Reset retains storage but leaves the port idle until reloaded.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("rr_active", {31'b0, instr_active}, 32'h0);
      check("rr_fault", {31'b0, fault}, 32'h0);
      check("rr_word0", instr_readdata, 32'h8C0C0000);
      check("rr_data_zero", data_readdata, 32'h0);
      init_mem = 1'b1;
      init_mem_addr = IB;
      init_instr = 32'h8C0C0000;
      tick();
      init_mem = 1'b0;
      #1;
      check("rr_loading_zero", data_readdata, 32'h0);
      tick();
      #1;
      check("rr_data_kept", data_readdata, 32'd104);

      // Window misses.
      instr_address = 32'h00400000;
      data_address = 32'hFFFFFFF0;
      #1;
      check("miss_fetch", instr_readdata, 32'h0);
      check("miss_load", data_readdata, 32'h0);
      tick();
      data_read = 1'b0;
      #1;
      check("miss_fault", {31'b0, fault}, 32'h1);
      check("miss_fault_addr", fault_addr, 32'hFFFFFFF0);

      reset = 1'b1;
      tick();
      reset = 1'b0;

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         int k;
         quiet();
         reset = ($urandom_range(0, 999) < 4);
         if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(1, 4);
         if (burst > 0) begin
            burst--;
            init_mem = 1'b1;
            k = $urandom_range(0, 7);
            if (k == 0) init_mem_addr = $urandom;
            else if (k == 1) init_mem_addr = IB + 32'(4 * $urandom_range(0, IWN - 1)) + 32'd2;
            else init_mem_addr = IB + 32'(4 * $urandom_range(0, IWN - 1));
            init_instr = $urandom;
         end
         clk_enable = ($urandom_range(0, 7) != 0);
         k = $urandom_range(0, 99);
         if (k < 40) data_read = 1'b1;
         else if (k < 75) data_write = 1'b1;
         else if (k < 77) begin
            data_read = 1'b1;
            data_write = 1'b1;
         end
         k = $urandom_range(0, 99);
         if (k < 92) data_address = 32'(4 * $urandom_range(0, 63));
         else if (k < 95) data_address = IB + 32'(4 * $urandom_range(0, IWN - 1));
         else if (k < 97) data_address = 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
         else data_address = 32'h10000000 + ($urandom & 32'h0FFFFFFC);
         data_writedata = $urandom;
         if ($urandom_range(0, 9) == 0) instr_address = $urandom;
         else instr_address = IB + 32'(4 * $urandom_range(0, IWN - 1));
         tick();
      end

      quiet();
      reset = 1'b0;
      tick();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
